// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data load/store port.
// Accepts one request at a time, waits LATENCY cycles, performs a
// little-endian byte/half/word access on an internal word array and
// returns a single-cycle response pulse carrying read data or an error.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] AddrLimit = 32'(4 * DEPTH_WORDS);
    localparam logic [CntW-1:0] CntLoad = (LATENCY > 0) ? CntW'(LATENCY - 1) : '0;
    localparam logic LatZero = (LATENCY == 0);

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;

    // Captured request
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Request view used by the access: live inputs when the access happens on
    // the accepting edge (LATENCY=0), captured registers otherwise.
    logic        acc_we;
    logic [1:0]  acc_size;
    logic        acc_uns;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    logic            acc_fire;
    logic            acc_err;
    logic [IdxW-1:0] acc_idx;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     load_data;
    logic [3:0]      wr_mask;
    logic [31:0]     wr_rep;
    logic [31:0]     wr_word;
    logic            mem_we;

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);

    // Select the request fields the access operates on
    always_comb begin
        if (state_q == StIdle) begin
            acc_we    = req_we;
            acc_size  = req_size;
            acc_uns   = req_unsigned;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    // Decide when the access happens and whether the request is legal
    always_comb begin
        acc_fire = 1'b0;
        if (state_q == StIdle) begin
            acc_fire = req_valid && LatZero;
        end else if (state_q == StWait) begin
            acc_fire = (cnt_q == '0);
        end

        acc_err = 1'b0;
        unique case (acc_size)
            SzByte:  acc_err = 1'b0;
            SzHalf:  acc_err = acc_addr[0];
            SzWord:  acc_err = |acc_addr[1:0];
            default: acc_err = 1'b1;
        endcase
        if (acc_addr >= AddrLimit) begin
            acc_err = 1'b1;
        end
    end

    assign acc_idx = acc_addr[IdxW+1:2];
    assign rd_word = mem_q[acc_idx];

    // Lane selection and sign/zero extension for loads
    always_comb begin
        rd_byte = 8'(rd_word >> {acc_addr[1:0], 3'b000});
        rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

        load_data = '0;
        unique case (acc_size)
            SzByte: load_data = acc_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SzHalf: load_data = acc_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            SzWord: load_data = rd_word;
            default: load_data = '0;
        endcase
        if (acc_err || acc_we) begin
            load_data = '0;
        end
    end

    // Byte-lane merge for stores; store data is right-aligned so replicate it
    always_comb begin
        wr_mask = 4'b0000;
        wr_rep  = acc_wdata;
        unique case (acc_size)
            SzByte: begin
                wr_mask = 4'b0001 << acc_addr[1:0];
                wr_rep  = {4{acc_wdata[7:0]}};
            end
            SzHalf: begin
                wr_mask = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_rep  = {2{acc_wdata[15:0]}};
            end
            SzWord: begin
                wr_mask = 4'b1111;
                wr_rep  = acc_wdata;
            end
            default: begin
                wr_mask = 4'b0000;
                wr_rep  = acc_wdata;
            end
        endcase

        wr_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) begin
                wr_word[8*b +: 8] = wr_rep[8*b +: 8];
            end
        end

        mem_we = acc_fire && acc_we && !acc_err;
    end

    // Storage: zeroed by reset, written only by a legal store on its access edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[acc_idx] <= wr_word;
        end
    end

    // Request FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= CntLoad;
                        if (LatZero) begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_rdata <= load_data;
                            resp_err   <= acc_err;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q    <= StResp;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        resp_err   <= acc_err;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    state_q    <= StIdle;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
